// File: rtl/vis_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyph table,
// dash/blank patterns, display mode enumeration and a power-of-ten helper.
package vis_pkg;
  typedef enum logic {MODE_HEX = 1'b0, MODE_DEC = 1'b1} mode_e;

  // {g,f,e,d,c,b,a}, active-low; entry 15 is leftmost
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
endpackage

// File: rtl/vis_scan_if.sv
// Host-side bundle of the scanner: load strobe with payload, status, and
// the multiplexed digit/segment drive.
interface vis_scan_if #(parameter int NDIG = 4);
  import vis_pkg::*;
  logic [4*NDIG-1:0] dat;
  logic [NDIG-1:0]   dp;
  mode_e             mode;
  logic              load;
  logic              busy;
  logic              ovf;
  logic [NDIG-1:0]   AN;
  logic [7:0]        SEG;

  modport master (output dat, dp, mode, load, input busy, ovf, AN, SEG);
  modport slave  (input dat, dp, mode, load, output busy, ovf, AN, SEG);
endinterface

// File: rtl/vis_bin2bcd.sv
// Iterative shift-add-3 binary to BCD converter; one bit per cycle, 4*NDIG
// cycles per conversion. bcd is valid in the cycle done is high.
module vis_bin2bcd #(parameter int NDIG = 4) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bin,
  output logic              done,
  output logic [4*NDIG-1:0] bcd
);
  localparam int W  = 4*NDIG;
  localparam int CW = $clog2(W);

  typedef enum logic {IDLE, RUN} st_e;
  st_e st, st_nxt;

  logic [W-1:0]  sh, sh_nxt, acc, acc_nxt, adj;
  logic [CW-1:0] cnt;

  always_comb begin
    adj = acc;
    for (int i = 0; i < NDIG; i++)
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    {acc_nxt, sh_nxt} = {adj, sh} << 1;
  end

  // the final step is exposed combinationally so the caller latches it on the done edge
  assign bcd = acc_nxt;

  always_comb begin
    st_nxt = st;
    done   = 1'b0;
    case (st)
      IDLE: if (start) st_nxt = RUN;
      RUN: if (cnt == CW'(W-1)) begin
        done   = 1'b1;
        st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= IDLE;
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      st <= st_nxt;
      if (st == IDLE && start) begin
        sh  <= bin;
        acc <= '0;
        cnt <= '0;
      end else if (st == RUN) begin
        sh  <= sh_nxt;
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vis_scan.sv
// Multiplexed seven-segment scanner with hex or decimal display of a loaded
// value. Define VIS_SCAN_LZB_EN to compile in decimal leading-zero blanking.
module vis_scan import vis_pkg::*; #(
  parameter int NDIG = 4,
  parameter int DIV  = 50000
) (
  input logic         F50MHz,
  input logic         BTN0,
  vis_scan_if.slave   bus
);
  localparam int W  = 4*NDIG;
  localparam int PW = $clog2(DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam longint unsigned LIM = pow10(NDIG);

  logic [PW-1:0]        pcnt;
  logic [IW-1:0]        idx, idx_nxt;
  logic                 wrap;
  logic [NDIG-1:0][3:0] disp;
  logic [NDIG-1:0]      dp_reg, dp_hold;
  logic                 dash;
  logic                 accept, start, big, done;
  logic [W-1:0]         bcd;
  logic [6:0]           glyph;

  assign wrap    = (pcnt == PW'(DIV-1));
  assign idx_nxt = !wrap ? idx : (idx == IW'(NDIG-1)) ? '0 : idx + 1'b1;
  assign accept  = bus.load && !bus.busy;
  assign big     = 64'(bus.dat) >= LIM;
  assign start   = accept && bus.mode == MODE_DEC && !big;

  vis_bin2bcd #(.NDIG(NDIG)) u_b2b (
    .clk(F50MHz), .rst(BTN0), .start(start), .bin(bus.dat), .done(done), .bcd(bcd)
  );

`ifdef VIS_SCAN_LZB_EN
  logic            dec;
  logic [NDIG-1:0] lz;
  always_comb begin
    lz[NDIG-1] = (disp[NDIG-1] == 4'd0);
    for (int i = NDIG-2; i >= 0; i--) lz[i] = lz[i+1] && (disp[i] == 4'd0);
    lz[0] = 1'b0;
  end
`endif

  always_comb begin
    glyph = dash ? SEG_DASH : HEX_SEG[disp[idx_nxt]];
`ifdef VIS_SCAN_LZB_EN
    if (!dash && dec && lz[idx_nxt]) glyph = SEG_BLANK;
`endif
  end

  always_ff @(posedge F50MHz or posedge BTN0) begin
    if (BTN0) begin
      pcnt     <= '0;
      idx      <= '0;
      disp     <= '0;
      dp_reg   <= '0;
      dp_hold  <= '0;
      dash     <= 1'b0;
      bus.busy <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.AN   <= ~NDIG'(1);
      bus.SEG  <= 8'hC0;
`ifdef VIS_SCAN_LZB_EN
      dec      <= 1'b0;
`endif
    end else begin
      pcnt    <= wrap ? '0 : pcnt + 1'b1;
      idx     <= idx_nxt;
      bus.AN  <= ~(NDIG'(1) << idx_nxt);
      bus.SEG <= {~dp_reg[idx_nxt], glyph};
      if (accept) begin
        bus.ovf <= (bus.mode == MODE_DEC) && big;
        if (bus.mode == MODE_HEX || big) begin
          disp   <= bus.dat;
          dp_reg <= bus.dp;
          dash   <= (bus.mode == MODE_DEC);
`ifdef VIS_SCAN_LZB_EN
          dec    <= 1'b0;
`endif
        end else begin
          dp_hold  <= bus.dp;
          bus.busy <= 1'b1;
        end
      end
      if (done) begin
        disp     <= bcd;
        dp_reg   <= dp_hold;
        dash     <= 1'b0;
        bus.busy <= 1'b0;
`ifdef VIS_SCAN_LZB_EN
        dec      <= 1'b1;
`endif
      end
    end
  end
endmodule
